// File: rtl/morse_letter_sequencer_pkg.sv
// morse_pkg: state encoding, code constants and gap defaults.
// MORSE_WORD_GAP_EN adds the WORDWAIT state.
package morse_pkg;

  localparam int CODE_W = 10;
  localparam int LETTER_GAP_DEF = 8;
  localparam int WORD_GAP_DEF = 20;
  localparam logic [CODE_W-1:0] SPACE_CODE =
    10'b10_0000_0000;

`ifdef MORSE_WORD_GAP_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_KEYING,
    S_CAPTURE,
    S_CLEAR,
    S_WORDWAIT
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_KEYING,
    S_CAPTURE,
    S_CLEAR
  } state_e;
`endif

  // Low-time counter: held at zero while keyed, saturates.
  function automatic logic [15:0] gap_step(
    input logic [15:0] g,
    input logic        key
  );
    if (key) return '0;
    if (g == 16'hFFFF) return g;
    return g + 16'd1;
  endfunction

endpackage

// File: rtl/morse_letter_sequencer_if.sv
// Symbol stream handshake between the sequencer
// and its consumer.
interface morse_sym_if;
  import morse_pkg::*;

  logic [CODE_W-1:0] sym_code;
  logic              sym_valid;
  logic              sym_ready;

  modport master (
    output sym_code,
    output sym_valid,
    input  sym_ready
  );

  modport slave (
    input  sym_code,
    input  sym_valid,
    output sym_ready
  );
endinterface

// File: rtl/morse_letter_sequencer_sym_fifo.sv
// morse_sym_fifo: power-of-two symbol queue with
// count, full/empty and same-cycle push+pop when full.
module morse_sym_fifo
  import morse_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [CODE_W-1:0]        wdata,
  input  logic                     pop,
  output logic [CODE_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CODE_W-1:0] mem_q [DEPTH];
  logic [CODE_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign count = cnt_q;
  assign rdata = empty ? '0 : mem_q[rd_q];

  // A full queue can still accept when its head leaves.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = wdata;
      wr_d = wr_q + 1'b1;
    end
    if (do_pop) rd_d = rd_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/morse_letter_sequencer.sv
// Morse letter sequencer: turns key gaps into letter
// captures and queues codes. MORSE_WORD_GAP_EN adds spaces.
module morse_letter_sequencer
  import morse_pkg::*;
#(
  parameter int LETTER_GAP = LETTER_GAP_DEF,
  parameter int WORD_GAP   = WORD_GAP_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          button,
  input  logic [CODE_W-1:0]             letter,
  output logic                          send,
  morse_sym_if.master                   sym,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  if (WORD_GAP <= LETTER_GAP + 1) begin : g_gap_chk
    $error("WORD_GAP must exceed LETTER_GAP + 1");
  end

  localparam logic [15:0] LG = 16'(LETTER_GAP);

  state_e            state_q, state_d;
  logic [15:0]       gap_q, gap_d;
  logic              ovf_q, ovf_d;
  logic              push, pop, full, empty;
  logic [CODE_W-1:0] push_data;

  assign pop = sym.sym_ready && !empty;

  always_comb begin
    state_d   = state_q;
    ovf_d     = ovf_q;
    push      = 1'b0;
    push_data = letter;
    gap_d     = gap_step(gap_q, button);
    unique case (state_q)
      S_IDLE:
        if (button) state_d = S_KEYING;
      S_KEYING:
        if (!button && gap_q == LG)
          state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (button) begin
          state_d = S_KEYING;
        end else begin
          if (letter != '0) begin
            if (full && !pop) ovf_d = 1'b1;
            else              push  = 1'b1;
          end
          state_d = S_CLEAR;
        end
      end
`ifdef MORSE_WORD_GAP_EN
      S_CLEAR:
        state_d = S_WORDWAIT;
      S_WORDWAIT: begin
        // The counter has already passed LETTER_GAP here.
        if (button) begin
          state_d = S_KEYING;
        end else if (gap_q >= 16'(WORD_GAP)) begin
          push_data = SPACE_CODE;
          if (full && !pop) ovf_d = 1'b1;
          else              push  = 1'b1;
          state_d = S_IDLE;
        end
      end
`else
      S_CLEAR:
        state_d = S_IDLE;
`endif
      default:
        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      ovf_q   <= ovf_d;
    end
  end

  // Encoder stays cleared for the whole reset.
  assign send     = (state_q == S_CLEAR) || rst;
  assign busy     = (state_q != S_IDLE);
  assign overflow = ovf_q;
  assign sym.sym_valid = !empty;

  morse_sym_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_data),
    .pop   (pop),
    .rdata (sym.sym_code),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

endmodule
